// File: rtl/acc_run_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : acc_run_seq_if
// Description : Command, accelerator-handshake and status bundle between the
//               wbsCtrl register block (master) and the run sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface acc_run_seq_if #(
   parameter int TO_W  = 16,
   parameter int CNT_W = 8
);
   // Commands from wbsCtrl
   logic             go;
   logic             abort;
   logic             skip_load;
   logic             skip_send;
   logic [TO_W-1:0]  timeout_cycles;
   // Completion pulses from the accelerator
   logic             acc_load_done;
   logic             acc_fsm_done;
   logic             acc_send_done;
   // Accelerator controls and status back to wbsCtrl
   logic             load_kdtree;
   logic             fsm_start;
   logic             send_best_arr;
   logic             busy;
   logic             done;
   logic [1:0]       err;
   logic [2:0]       phase;
   logic [CNT_W-1:0] run_count;

   modport master (
      output go, abort, skip_load, skip_send, timeout_cycles,
      output acc_load_done, acc_fsm_done, acc_send_done,
      input  load_kdtree, fsm_start, send_best_arr, busy, done, err, phase,
      input  run_count
   );

   modport slave (
      input  go, abort, skip_load, skip_send, timeout_cycles,
      input  acc_load_done, acc_fsm_done, acc_send_done,
      output load_kdtree, fsm_start, send_best_arr, busy, done, err, phase,
      output run_count
   );
endinterface
`default_nettype wire

// File: rtl/acc_run_seq.sv
`default_nettype none
// ============================================================================
// Module      : acc_run_seq
// Description : Run sequencer for the kd-tree ANN accelerator. A single go
//               steps through LOAD -> START -> SEARCH -> SEND -> DONE with a
//               per-wait-phase watchdog and an abort path into ERR.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_run_seq #(
   parameter int TO_W  = 16,
   parameter int CNT_W = 8
) (
   input  wire logic          wb_clk_i,
   input  wire logic          wb_rst_i,
   acc_run_seq_if.slave       bus
);

   // State codes double as the phase status value.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_START  = 3'd2,
      S_SEARCH = 3'd3,
      S_SEND   = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_ABORT   = 2'd2;

   state_t           state_q,       state_d;
   logic [TO_W-1:0]  wd_q,          wd_d;
   logic [1:0]       err_q,         err_d;
   logic             skip_load_q,   skip_load_d;
   logic             skip_send_q,   skip_send_d;
   logic [CNT_W-1:0] run_count_q,   run_count_d;
   logic             load_kdtree_q, load_kdtree_d;
   logic             fsm_start_q,   fsm_start_d;
   logic             send_best_q,   send_best_d;
   logic             busy_q,        busy_d;
   logic             done_q,        done_d;
   logic [2:0]       phase_q,       phase_d;

   logic             wd_expired;
   logic [TO_W-1:0]  wd_next;

   // Watchdog decision for the current wait cycle and its saturating step.
   always_comb begin
      wd_expired = (bus.timeout_cycles != '0) && (wd_q == bus.timeout_cycles);
      wd_next    = (&wd_q) ? wd_q : wd_q + TO_W'(1);
   end

   // Next-state, watchdog, error and counter logic; outputs decode next state.
   always_comb begin
      state_d     = state_q;
      wd_d        = wd_q;
      err_d       = err_q;
      skip_load_d = skip_load_q;
      skip_send_d = skip_send_q;
      run_count_d = run_count_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            // abort is meaningless when not busy, so go always wins here
            if (bus.go) begin
               err_d       = ERR_NONE;
               skip_load_d = bus.skip_load;
               skip_send_d = bus.skip_send;
               wd_d        = '0;
               state_d     = bus.skip_load ? S_START : S_LOAD;
            end
         end
         S_LOAD: begin
            if (bus.abort) begin
               state_d = S_ERR;
               err_d   = ERR_ABORT;
            end else if (bus.acc_load_done) begin
               state_d = S_START;
            end else if (wd_expired) begin
               state_d = S_ERR;
               err_d   = ERR_TIMEOUT;
            end else begin
               wd_d = wd_next;
            end
         end
         S_START: begin
            // acc_fsm_done here is deliberately ignored: search has not begun
            if (bus.abort) begin
               state_d = S_ERR;
               err_d   = ERR_ABORT;
            end else begin
               state_d = S_SEARCH;
               wd_d    = '0;
            end
         end
         S_SEARCH: begin
            if (bus.abort) begin
               state_d = S_ERR;
               err_d   = ERR_ABORT;
            end else if (bus.acc_fsm_done) begin
               state_d = skip_send_q ? S_DONE : S_SEND;
               wd_d    = '0;
            end else if (wd_expired) begin
               state_d = S_ERR;
               err_d   = ERR_TIMEOUT;
            end else begin
               wd_d = wd_next;
            end
         end
         S_SEND: begin
            if (bus.abort) begin
               state_d = S_ERR;
               err_d   = ERR_ABORT;
            end else if (bus.acc_send_done) begin
               state_d = S_DONE;
            end else if (wd_expired) begin
               state_d = S_ERR;
               err_d   = ERR_TIMEOUT;
            end else begin
               wd_d = wd_next;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Count only true entries into DONE (DONE never re-enters itself).
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         run_count_d = run_count_q + CNT_W'(1);
      end

      load_kdtree_d = (state_d == S_LOAD);
      fsm_start_d   = (state_d == S_START);
      send_best_d   = (state_d == S_SEND);
      busy_d        = (state_d == S_LOAD) || (state_d == S_START) ||
                      (state_d == S_SEARCH) || (state_d == S_SEND);
      done_d        = (state_d == S_DONE);
      phase_d       = state_d;
   end

   // Single register stage for state, watchdog, latched flags and outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q       <= S_IDLE;
         wd_q          <= '0;
         err_q         <= ERR_NONE;
         skip_load_q   <= 1'b0;
         skip_send_q   <= 1'b0;
         run_count_q   <= '0;
         load_kdtree_q <= 1'b0;
         fsm_start_q   <= 1'b0;
         send_best_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         phase_q       <= 3'd0;
      end else begin
         state_q       <= state_d;
         wd_q          <= wd_d;
         err_q         <= err_d;
         skip_load_q   <= skip_load_d;
         skip_send_q   <= skip_send_d;
         run_count_q   <= run_count_d;
         load_kdtree_q <= load_kdtree_d;
         fsm_start_q   <= fsm_start_d;
         send_best_q   <= send_best_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         phase_q       <= phase_d;
      end
   end

   assign bus.load_kdtree   = load_kdtree_q;
   assign bus.fsm_start     = fsm_start_q;
   assign bus.send_best_arr = send_best_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
   assign bus.phase         = phase_q;
   assign bus.run_count     = run_count_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_run_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_run_seq
// Description : Table-driven directed bench for acc_run_seq plus hand-written
//               counter-wrap and mid-run reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_acc_run_seq;

   localparam int TO_W  = 16;
   localparam int CNT_W = 8;

   logic wb_clk_i = 1'b0;
   logic wb_rst_i;

   always #5 wb_clk_i = ~wb_clk_i;

   acc_run_seq_if #(.TO_W(TO_W), .CNT_W(CNT_W)) bus ();

   acc_run_seq #(.TO_W(TO_W), .CNT_W(CNT_W)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .bus      (bus)
   );

   // One row: inputs held for n cycles, expected phase/err/run_count after each.
   typedef struct packed {
      int          n;
      logic        go;
      logic        ab;
      logic        sl;
      logic        ss;
      logic [15:0] to;
      logic        ld;
      logic        fd;
      logic        sd;
      logic [2:0]  ph;
      logic [1:0]  er;
      logic [7:0]  rc;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t v(int n, logic go, logic ab, logic sl, logic ss,
                              logic [15:0] to, logic ld, logic fd, logic sd,
                              logic [2:0] ph, logic [1:0] er, logic [7:0] rc);
      vec_t r;
      r.n = n; r.go = go; r.ab = ab; r.sl = sl; r.ss = ss; r.to = to;
      r.ld = ld; r.fd = fd; r.sd = sd; r.ph = ph; r.er = er; r.rc = rc;
      return r;
   endfunction

   task automatic drive(logic go, logic ab, logic sl, logic ss, logic [15:0] to,
                        logic ld, logic fd, logic sd);
      bus.go             = go;
      bus.abort          = ab;
      bus.skip_load      = sl;
      bus.skip_send      = ss;
      bus.timeout_cycles = to;
      bus.acc_load_done  = ld;
      bus.acc_fsm_done   = fd;
      bus.acc_send_done  = sd;
   endtask

   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   // Control/status flags follow directly from the expected phase.
   task automatic check_out(string name, logic [2:0] ph, logic [1:0] er, logic [7:0] rc);
      logic [17:0] exp_v, act_v;
      exp_v = {ph, er, (ph == 3'd5), (ph >= 3'd1 && ph <= 3'd4),
               (ph == 3'd1), (ph == 3'd2), (ph == 3'd4), rc};
      act_v = {bus.phase, bus.err, bus.done, bus.busy, bus.load_kdtree,
               bus.fsm_start, bus.send_best_arr, bus.run_count};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got ph=%0d err=%0d done/busy/ld/st/sd=%b rc=%0d, required ph=%0d err=%0d done/busy/ld/st/sd=%b rc=%0d",
                  name, act_v[17:15], act_v[14:13], act_v[12:8], act_v[7:0],
                  exp_v[17:15], exp_v[14:13], exp_v[12:8], exp_v[7:0]);
      end
   endtask

   initial begin
      logic [7:0] exp_rc;

      // Full run, watchdog disabled
      tbl.push_back(v( 1, 1,0,0,0, 16'd0, 0,0,0, 3'd1, 2'd0, 8'd0));
      tbl.push_back(v( 4, 0,0,0,0, 16'd0, 0,0,0, 3'd1, 2'd0, 8'd0));
      tbl.push_back(v( 1, 0,0,0,0, 16'd0, 1,0,0, 3'd2, 2'd0, 8'd0));
      tbl.push_back(v( 1, 0,0,0,0, 16'd0, 0,0,0, 3'd3, 2'd0, 8'd0));
      tbl.push_back(v(19, 0,0,0,0, 16'd0, 0,0,0, 3'd3, 2'd0, 8'd0));
      tbl.push_back(v( 1, 0,0,0,0, 16'd0, 0,1,0, 3'd4, 2'd0, 8'd0));
      tbl.push_back(v( 3, 0,0,0,0, 16'd0, 0,0,0, 3'd4, 2'd0, 8'd0));
      tbl.push_back(v( 1, 0,0,0,0, 16'd0, 0,0,1, 3'd5, 2'd0, 8'd1));
      tbl.push_back(v( 2, 0,0,0,0, 16'd0, 0,0,0, 3'd5, 2'd0, 8'd1));
      // Both skips; acc_fsm_done during START is ignored
      tbl.push_back(v( 1, 1,0,1,1, 16'd0, 0,0,0, 3'd2, 2'd0, 8'd1));
      tbl.push_back(v( 1, 0,0,0,0, 16'd0, 0,1,0, 3'd3, 2'd0, 8'd1));
      tbl.push_back(v( 1, 0,0,0,0, 16'd0, 0,1,0, 3'd5, 2'd0, 8'd2));
      // LOAD timeout with T=4: LOAD cycles 0..4, then ERR (sticky)
      tbl.push_back(v( 1, 1,0,0,0, 16'd4, 0,0,0, 3'd1, 2'd0, 8'd2));
      tbl.push_back(v( 4, 0,0,0,0, 16'd4, 0,0,0, 3'd1, 2'd0, 8'd2));
      tbl.push_back(v( 2, 0,0,0,0, 16'd4, 0,0,0, 3'd6, 2'd1, 8'd2));
      // Load done on LOAD cycle 4 is still accepted
      tbl.push_back(v( 1, 1,0,0,0, 16'd4, 0,0,0, 3'd1, 2'd0, 8'd2));
      tbl.push_back(v( 4, 0,0,0,0, 16'd4, 0,0,0, 3'd1, 2'd0, 8'd2));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 1,0,0, 3'd2, 2'd0, 8'd2));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 0,0,0, 3'd3, 2'd0, 8'd2));
      // Abort beats acc_fsm_done in the same SEARCH cycle
      tbl.push_back(v( 1, 0,1,0,0, 16'd4, 0,1,0, 3'd6, 2'd2, 8'd2));
      // go with abort in ERR: go taken, err cleared
      tbl.push_back(v( 1, 1,1,1,1, 16'd4, 0,0,0, 3'd2, 2'd0, 8'd2));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 0,0,0, 3'd3, 2'd0, 8'd2));
      // go while busy ignored (and does not relatch skip_send)
      tbl.push_back(v( 2, 1,0,0,0, 16'd4, 0,0,0, 3'd3, 2'd0, 8'd2));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 0,1,0, 3'd5, 2'd0, 8'd3));
      // Stray done pulses outside their wait state
      tbl.push_back(v( 1, 1,0,0,0, 16'd4, 0,0,0, 3'd1, 2'd0, 8'd3));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 0,0,1, 3'd1, 2'd0, 8'd3));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 1,0,0, 3'd2, 2'd0, 8'd3));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 0,0,0, 3'd3, 2'd0, 8'd3));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 0,1,0, 3'd4, 2'd0, 8'd3));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 1,0,0, 3'd4, 2'd0, 8'd3));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 0,0,1, 3'd5, 2'd0, 8'd4));
      // SEARCH timeout with T=4
      tbl.push_back(v( 1, 1,0,1,0, 16'd4, 0,0,0, 3'd2, 2'd0, 8'd4));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 0,0,0, 3'd3, 2'd0, 8'd4));
      tbl.push_back(v( 4, 0,0,0,0, 16'd4, 0,0,0, 3'd3, 2'd0, 8'd4));
      tbl.push_back(v( 1, 0,0,0,0, 16'd4, 0,0,0, 3'd6, 2'd1, 8'd4));

      // Reset (go held high must not escape IDLE)
      drive(1, 0, 0, 0, 16'd0, 0, 0, 0);
      wb_rst_i = 1'b1;
      step();
      step();
      check_out("reset", 3'd0, 2'd0, 8'd0);
      wb_rst_i = 1'b0;
      drive(0, 0, 0, 0, 16'd0, 0, 0, 0);
      step();
      check_out("idle_after_reset", 3'd0, 2'd0, 8'd0);

      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            drive(tbl[i].go, tbl[i].ab, tbl[i].sl, tbl[i].ss, tbl[i].to,
                  tbl[i].ld, tbl[i].fd, tbl[i].sd);
            step();
            check_out($sformatf("vec%0d_c%0d", i, k), tbl[i].ph, tbl[i].er, tbl[i].rc);
         end
      end
      drive(0, 0, 0, 0, 16'd0, 0, 0, 0);

      // Run counter wrap: minimum-length runs until run_count passes 255 -> 0
      exp_rc = 8'd4;
      for (int r = 0; r < 252; r++) begin
         drive(1, 0, 1, 1, 16'd0, 0, 0, 0);
         step();
         drive(0, 0, 0, 0, 16'd0, 0, 0, 0);
         step();
         drive(0, 0, 0, 0, 16'd0, 0, 1, 0);
         step();
         exp_rc = exp_rc + 8'd1;
         check_out($sformatf("wrap_run%0d", r), 3'd5, 2'd0, exp_rc);
      end
      drive(0, 0, 0, 0, 16'd0, 0, 0, 0);
      check_out("wrap_zero", 3'd5, 2'd0, 8'd0);

      // One more run so the reset below has a nonzero count to clear
      drive(1, 0, 1, 1, 16'd0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 16'd0, 0, 1, 0);
      step();
      step();
      check_out("post_wrap_run", 3'd5, 2'd0, 8'd1);

      // Reset while in SEND
      drive(1, 0, 1, 0, 16'd0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 16'd0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 16'd0, 0, 1, 0);
      step();
      check_out("send_before_reset", 3'd4, 2'd0, 8'd1);
      drive(0, 0, 0, 0, 16'd0, 0, 0, 1);
      wb_rst_i = 1'b1;
      step();
      check_out("reset_in_send", 3'd0, 2'd0, 8'd0);
      wb_rst_i = 1'b0;
      drive(0, 0, 0, 0, 16'd0, 0, 0, 0);
      step();
      check_out("idle_after_midrun_reset", 3'd0, 2'd0, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/acc_run_seq.md
# acc_run_seq

Run sequencer for the kd-tree ANN accelerator, clocked in the Wishbone domain. On a single `go` command it steps the accelerator through three phases: kd-tree load, search FSM start/completion, and best-array send-back. It drives the `load_kdtree`, `fsm_start` and `send_best_arr` controls and reports phase, completion, error and run count to the wbsCtrl status registers. A per-phase watchdog and an abort input guarantee return to a restartable state.

## Interface
- `TO_W`, 16: width of watchdog limit and counter.
- `CNT_W`, 8: width of completed-run counter.

- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `go`  in  1  start command, one-cycle pulse.
- `abort`  in  1  abort command, level or pulse.
- `skip_load`  in  1  sampled with `go`; bypass the LOAD phase.
- `skip_send`  in  1  sampled with `go`; bypass the SEND phase.
- `timeout_cycles`  in  TO_W  watchdog limit per wait phase; 0 disables the watchdog.
- `acc_load_done`  in  1  pulse: kd-tree load complete.
- `acc_fsm_done`  in  1  pulse: search complete.
- `acc_send_done`  in  1  pulse: best-array send complete.
- `load_kdtree`  out  1  high throughout LOAD.
- `fsm_start`  out  1  one-cycle pulse, asserted in START.
- `send_best_arr`  out  1  high throughout SEND.
- `busy`  out  1  high in LOAD/START/SEARCH/SEND.
- `done`  out  1  sticky; high in DONE.
- `err`  out  2  0 = none, 1 = timeout, 2 = abort; sticky while in ERR.
- `phase`  out  3  state code: IDLE 0, LOAD 1, START 2, SEARCH 3, SEND 4, DONE 5, ERR 6.
- `run_count`  out  CNT_W  count of runs that reached DONE; wraps modulo 2^CNT_W.

## Operation
- State transitions:
  - IDLE/DONE/ERR + `go` → LOAD, or → START if `skip_load`. This clears `done` and `err` and latches both skip flags.
  - LOAD + `acc_load_done` → START.
  - START → SEARCH unconditionally, after exactly one cycle.
  - SEARCH + `acc_fsm_done` → SEND, or → DONE if latched `skip_send`.
  - SEND + `acc_send_done` → DONE.
- `go` while `busy` is ignored. A done pulse outside its matching wait state is ignored, including `acc_fsm_done` during START.
- Watchdog:
  - Counter `wd` is cleared on entry to LOAD, SEARCH and SEND.
  - In a wait state, on a cycle without the matching done: if `timeout_cycles` ≠ 0 and `wd` == `timeout_cycles`, go to ERR with `err`=1. Otherwise `wd` increments, saturating at all-ones.
  - Done pulses are accepted on wait cycles 0..T inclusive, counted from entry.
- Priority within a cycle: `abort` (when busy) > matching done > timeout.
- `abort` in any busy state → ERR with `err`=2. `abort` in IDLE/DONE/ERR is ignored; if `go` arrives in the same cycle, `go` is taken.
- On entry to DONE, `run_count` increments; 2^CNT_W−1 wraps to 0.
- All outputs are registered and decoded from the next state, so each is valid in the first cycle of its state.

## Timing
- Reset: the edge with `wb_rst_i`=1 forces IDLE. `load_kdtree`, `fsm_start`, `send_best_arr`, `busy`, `done` = 0; `err` = 0; `phase` = 0; `run_count` = 0; `wd` = 0.
- Reset mid-run drops all controls at the next edge; no completion is counted.
- Sampling `go` at edge N gives `phase`/`busy`/`load_kdtree` valid after edge N (cycle N+1). With `skip_load`, `fsm_start` is high in cycle N+1.
- A done pulse sampled at edge M causes the control deassert and next-phase outputs in cycle M+1.
- `fsm_start` is high for exactly one cycle per run. `load_kdtree` and `send_best_arr` never overlap `fsm_start`.
- Minimum run with both skips: `go`, START, SEARCH, then `acc_fsm_done` in the first SEARCH cycle → DONE 3 cycles after `go`.
- Abort or timeout deasserts all controls in the cycle after the decision edge.

## Test plan
- Full run, `timeout_cycles`=0: `go`; `acc_load_done` 5 cycles later; `acc_fsm_done` 20 cycles after START; `acc_send_done` 4 cycles after SEND entry.
  - Required: `phase` 1→2→3→4→5; `fsm_start` high exactly 1 cycle; `done`=1; `run_count`=1; `err`=0.
- Skips: `go` with `skip_load`=1, `skip_send`=1; `acc_fsm_done` on the first SEARCH cycle.
  - Required: `load_kdtree` and `send_best_arr` never high; DONE 3 cycles after `go`.
- Watchdog: `timeout_cycles`=4, no `acc_load_done`.
  - Required: ERR entered 6 cycles after `go` (LOAD cycles 0..4, then ERR); `err`=1; `load_kdtree` low.
  - Repeat with `acc_load_done` on LOAD cycle 4: required START, no error.
- Abort priority: `abort` and `acc_fsm_done` in the same SEARCH cycle.
  - Required: ERR with `err`=2, no SEND, `run_count` unchanged.
  - Then `go`: required `err` cleared and a new run starts.
- Ignore rules: `go` pulses while in SEARCH, and a stray `acc_send_done` in LOAD.
  - Required: no state change from either.
- Wrap and reset: 256 full runs with CNT_W=8 → `run_count`=0. Then `wb_rst_i` asserted during SEND.
  - Required: all outputs 0 and `phase`=0 on the next cycle.
